// File: rtl/das_delay_line.sv
// Per-channel integer sample delay line for the delay-and-sum beamformer.
// Optional linear fractional interpolation is enabled by defining DAS_DLY_INTERP_EN.
module das_delay_line #(
    parameter int DATA_W    = 16,
    parameter int PROD_W    = 29,
    parameter int FRAC_BITS = 16,
    parameter int ADDR_W    = 6
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic [PROD_W-1:0]   delay_prod,
    input  logic                delay_vld,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                sat,
    input  logic                sat_clr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int INT_W = PROD_W - FRAC_BITS;
`ifdef DAS_DLY_INTERP_EN
    localparam int D_MAX = DEPTH - 2;
`else
    localparam int D_MAX = DEPTH - 1;
`endif

    typedef enum logic {FILL, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W-1:0]   d_q, d_d;
    logic [ADDR_W-1:0]   pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic [ADDR_W:0]     fill_q, fill_d;
    logic                sat_q, sat_d;
    logic                m_valid_q, m_valid_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [INT_W-1:0]    d_int;
    logic                clamp;
    logic [ADDR_W-1:0]   d_req;
    logic [ADDR_W-1:0]   d_eff;
    logic [ADDR_W-1:0]   raddr;
    logic                predate;
    logic [DATA_W-1:0]   x0;
    logic                advance;
    logic                accept;

    assign d_int   = delay_prod[PROD_W-1:FRAC_BITS];
    assign clamp   = d_int > INT_W'(D_MAX);
    assign d_req   = clamp ? ADDR_W'(D_MAX) : d_int[ADDR_W-1:0];
    assign d_eff   = pend_vld_q ? pend_q : d_q;
    assign raddr   = wptr_q - d_eff;
    // During fill, a delay reaching back past reset must yield silence, not stale RAM.
    assign predate = (state_q == FILL) && ({1'b0, d_eff} > fill_q);
    assign x0      = predate ? '0 : ((d_eff == '0) ? s_data : mem[raddr]);
    assign advance = !m_valid_q || m_ready;
    assign accept  = s_valid && advance;

    assign s_ready = advance;
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign sat     = sat_q;

`ifdef DAS_DLY_INTERP_EN
    localparam logic signed [DATA_W+1:0] Y_MAX = (DATA_W+2)'((2 ** (DATA_W-1)) - 1);
    localparam logic signed [DATA_W+1:0] Y_MIN = -(DATA_W+2)'(2 ** (DATA_W-1));

    logic [7:0]               w_q, w_d, pend_w_q, pend_w_d, ws_q, ws_d, w_eff;
    logic                     v1_q, v1_d;
    logic [DATA_W-1:0]        a_q, a_d, b_q, b_d;
    logic [ADDR_W-1:0]        raddr1;
    logic                     predate1;
    logic [DATA_W-1:0]        x1;
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W+9:0] prod;
    logic signed [DATA_W+1:0] shifted;
    logic signed [DATA_W+1:0] sum;
    logic [DATA_W-1:0]        y;

    assign w_eff    = pend_vld_q ? pend_w_q : w_q;
    assign raddr1   = raddr - ADDR_W'(1);
    assign predate1 = (state_q == FILL) && (({1'b0, d_eff} + (ADDR_W+1)'(1)) > fill_q);
    assign x1       = predate1 ? '0 : mem[raddr1];
    assign diff     = $signed({b_q[DATA_W-1], b_q}) - $signed({a_q[DATA_W-1], a_q});
    assign prod     = (DATA_W+10)'(diff) * (DATA_W+10)'($signed({1'b0, ws_q}));
    assign shifted  = prod[DATA_W+9:8];
    assign sum      = (DATA_W+2)'($signed(a_q)) + shifted;

    always_comb begin
        y = sum[DATA_W-1:0];
        if (sum > Y_MAX) begin
            y = Y_MAX[DATA_W-1:0];
        end else if (sum < Y_MIN) begin
            y = Y_MIN[DATA_W-1:0];
        end
    end
`endif

    // Delay update is deferred to the next accepted sample so the tap never moves mid-sample.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        d_d        = d_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        fill_d     = fill_q;
        sat_d      = sat_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
`ifdef DAS_DLY_INTERP_EN
        w_d        = w_q;
        pend_w_d   = pend_w_q;
        ws_d       = ws_q;
        v1_d       = v1_q;
        a_d        = a_q;
        b_d        = b_q;
`endif

        if (sat_clr) begin
            sat_d = 1'b0;
        end
        if (delay_vld && clamp) begin
            sat_d = 1'b1;
        end

        if (accept) begin
            d_d        = d_eff;
            pend_vld_d = 1'b0;
            wptr_d     = wptr_q + ADDR_W'(1);
            if (fill_q != (ADDR_W+1)'(DEPTH)) begin
                fill_d = fill_q + (ADDR_W+1)'(1);
            end
            if (fill_q == (ADDR_W+1)'(DEPTH-2)) begin
                state_d = RUN;
            end
`ifdef DAS_DLY_INTERP_EN
            w_d = w_eff;
`endif
        end

        if (delay_vld) begin
            pend_d     = d_req;
            pend_vld_d = 1'b1;
`ifdef DAS_DLY_INTERP_EN
            pend_w_d   = delay_prod[FRAC_BITS-1 -: 8];
`endif
        end

        if (advance) begin
`ifdef DAS_DLY_INTERP_EN
            v1_d      = accept;
            m_valid_d = v1_q;
            if (v1_q) begin
                m_data_d = y;
            end
            if (accept) begin
                a_d  = x0;
                b_d  = x1;
                ws_d = w_eff;
            end
`else
            m_valid_d = accept;
            if (accept) begin
                m_data_d = x0;
            end
`endif
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= FILL;
            wptr_q     <= '0;
            d_q        <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            fill_q     <= '0;
            sat_q      <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
`ifdef DAS_DLY_INTERP_EN
            w_q        <= '0;
            pend_w_q   <= '0;
            ws_q       <= '0;
            v1_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            d_q        <= d_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            fill_q     <= fill_d;
            sat_q      <= sat_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
`ifdef DAS_DLY_INTERP_EN
            w_q        <= w_d;
            pend_w_q   <= pend_w_d;
            ws_q       <= ws_d;
            v1_q       <= v1_d;
            a_q        <= a_d;
            b_q        <= b_d;
`endif
        end
    end

    // Sample RAM is intentionally not reset; the fill counter masks stale contents.
    always_ff @(posedge ap_clk) begin
        if (accept) begin
            mem[wptr_q] <= s_data;
        end
    end

endmodule

// File: doc/das_delay_line.md
Name: das_delay_line

Overview:
- Per-channel integer sample delay line for the delay-and-sum beamformer.
- Sits directly downstream of the steering-delay multiplier. Consumes its unsigned 29-bit fixed-point delay product, quantises it to a whole-sample delay, and outputs each channel sample delayed by that amount.
- Output feeds the channel summation stage.
- One instance per array element.

Parameters:
- DATA_W, 16, signed sample width
- PROD_W, 29, width of the delay product from the multiplier
- FRAC_BITS, 16, fractional bits in the delay product
- ADDR_W, 6, log2 of buffer depth; DEPTH = 2**ADDR_W = 64

Ports:
- ap_clk  in  1  clock, all state on rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- delay_prod  in  PROD_W  unsigned delay in samples, FRAC_BITS fractional bits
- delay_vld  in  1  one-cycle strobe, delay_prod valid
- s_data  in  DATA_W  input sample
- s_valid  in  1  input sample valid
- s_ready  out  1  input accepted when s_valid && s_ready
- m_data  out  DATA_W  delayed sample
- m_valid  out  1  output valid
- m_ready  in  1  downstream accepts when m_valid && m_ready
- sat  out  1  sticky: requested delay exceeded DEPTH-1
- sat_clr  in  1  clears sat

Behaviour:
- Reset (async assert, sync-released use): m_valid=0, m_data=0, sat=0, s_ready=1. Write pointer, fill count, active delay D and pending-delay register all cleared; state FILL. Buffer RAM is not cleared. Zero output during fill is guaranteed by the fill counter.
- Quantisation: D_req = delay_prod >> FRAC_BITS (truncate, no rounding). If D_req > DEPTH-1, D_req = DEPTH-1 and sat is set.
- delay_vld: D_req is captured into a pending register. D becomes D_req at the next accepted input sample, never between samples. If two strobes arrive before a sample, the last one wins.
- sat: set on a clamped strobe, cleared by sat_clr. If a clamped strobe and sat_clr occur in the same cycle, set wins.
- Handshake:
  - s_ready = !m_valid || m_ready (single output register, no skid buffer).
  - On accept: the sample is written at wptr, wptr increments modulo DEPTH, and the output register loads the sample read at (wptr - D) mod DEPTH using the updated D. D=0 returns the current input sample.
  - Latency is 1 cycle, accept to m_valid.
  - m_valid clears when m_ready is high and no new accept occurs.
  - m_data holds stable while m_valid && !m_ready.
- State machine:
  - FILL: fill count = samples accepted since reset, saturating at DEPTH. Output is 0 when D > fill count (the requested sample predates reset). FILL -> RUN when fill count reaches DEPTH-1.
  - RUN: output always comes from the buffer.
  - No transition back to FILL except via reset.
- Wrap-around: the read address is computed modulo DEPTH in ADDR_W bits. D=DEPTH-1 reads the slot about to be overwritten next, which is correct because the read occurs before the overwrite.
- Reset mid-stream: all outputs return to reset values immediately. Any in-flight output is discarded.
- Throughput: 1 sample per clock when m_ready is held high.

Optional Feature:
- Macro DAS_DLY_INTERP_EN.
- Defined:
  - Linear fractional interpolation.
  - Weight w = top 8 bits of the fractional field.
  - y = x[n-D] + (((x[n-D-1] - x[n-D]) * w) >>> 8), with arithmetic shift and the difference computed at DATA_W+1 bits.
  - Result saturates to DATA_W.
  - Adds one pipeline register, so latency is 2. Handshake becomes a 2-deep valid pipeline stalled as a whole by !m_ready.
  - The clamp limit becomes DEPTH-2.
  - x[n-D-1] reads as 0 when it predates reset.
- Undefined: fraction ignored, latency 1, as described above.

Test Plan:
- Reset, then delay_prod=0x30000 strobe (D=3), feed ramp 1,2,3,... with m_ready=1 -> m_data sequence 0,0,0,1,2,3...; m_valid one cycle after each accept.
- D=0, feed 0x7FFF then 0x8000 -> m_data 0x7FFF then 0x8000 with latency 1.
- delay_prod=100<<16 -> sat=1, behaves as D=63; sample k output equals sample k-63. Assert sat_clr the same cycle as a second clamped strobe -> sat stays 1.
- Running D=5, strobe D=2 between samples 20 and 21 -> output for sample 21 is sample 19. No glitch or extra output beat.
- Backpressure: hold m_ready=0 for 4 cycles with s_valid=1 -> s_ready=0, m_data stable, no sample lost. Release -> stream continues in order.
- DAS_DLY_INTERP_EN: D=1.5 (0x18000), input 0,100,200,... -> steady state m_data = x[n-1] - 50 (e.g. 150 when x[n]=300), latency 2.
